pong_match_ctrl: RTL and testbench

Match-level sequencer for the pong game: owns game state (idle, serve, play, point, pause, game over), the two player scores and the winner. It gates ball and paddle animation, commands ball re-centring and serve direction, and counts frames for serve and point delays. It sits between the VGA-timed drawing/animation logic, which supplies frame ticks and edge-miss events, and the board buttons.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/frame_delay_timer.sv | 29 ++
 rtl/pong_match_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong match sequencer: game states,
// winner codes and serve directions.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/frame_delay_timer.sv
// Loadable down-counter of video frames; flags the tick that
// arrives once the count has already reached zero.
module frame_delay_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] load_val,
    input  logic         load,
    input  logic         frame_tick,
    input  logic         hold,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold && frame_tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = frame_tick && (count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: game state, scores, winner, and the
// ball/paddle gating derived from them.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [2:0]         state,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               paddle_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner
);

    localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ?
                          SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W = (MAXF > 1) ? $clog2(MAXF) : 1;
    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t cur, nxt;
    logic start_q, start_p, pause_q, pause_p;
    logic start_edge, pause_edge;
    logic [SCORE_W-1:0] p1_inc, p2_inc, p1_nxt, p2_nxt;
    logic [1:0] win_nxt;
    logic dir_nxt, rst_nxt, load, hold, done;
    logic [CNT_W-1:0] load_val;

    assign start_edge = start_q & ~start_p;
    assign pause_edge = pause_q & ~pause_p;
    assign state = cur;
    assign hold = !(cur == ST_SERVE || cur == ST_POINT);

    // Saturating increments keep an illegal WIN_SCORE from wrapping.
    assign p1_inc = (score_p1 == '1) ? score_p1 : score_p1 + SCORE_W'(1);
    assign p2_inc = (score_p2 == '1) ? score_p2 : score_p2 + SCORE_W'(1);

    frame_delay_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_val  (load_val),
        .load      (load),
        .frame_tick(frame_tick),
        .hold      (hold),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= ST_IDLE;
            start_q    <= 1'b0;
            start_p    <= 1'b0;
            pause_q    <= 1'b0;
            pause_p    <= 1'b0;
            score_p1   <= '0;
            score_p2   <= '0;
            winner     <= WIN_NONE;
            serve_dir  <= DIR_RIGHT;
            ball_reset <= 1'b0;
            ball_run   <= 1'b0;
            paddle_en  <= 1'b0;
        end else begin
            cur        <= nxt;
            start_q    <= btn_start;
            start_p    <= start_q;
            pause_q    <= btn_pause;
            pause_p    <= pause_q;
            score_p1   <= p1_nxt;
            score_p2   <= p2_nxt;
            winner     <= win_nxt;
            serve_dir  <= dir_nxt;
            ball_reset <= rst_nxt;
            ball_run   <= (cur == ST_PLAY);
            paddle_en  <= (cur == ST_SERVE) || (cur == ST_PLAY);
        end
    end

    always_comb begin
        nxt      = cur;
        p1_nxt   = score_p1;
        p2_nxt   = score_p2;
        win_nxt  = winner;
        dir_nxt  = serve_dir;
        rst_nxt  = 1'b0;
        load     = 1'b0;
        load_val = SERVE_LD;
        unique case (cur)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    nxt     = ST_SERVE;
                    p1_nxt  = '0;
                    p2_nxt  = '0;
                    win_nxt = WIN_NONE;
                    rst_nxt = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_SERVE: begin
                if (done) nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    nxt     = ST_SERVE;
                    rst_nxt = 1'b1;
                    load    = 1'b1;
                end else if (miss_left) begin
                    p2_nxt  = p2_inc;
                    dir_nxt = DIR_LEFT;
                    if (p2_inc == WIN_VAL) begin
                        nxt     = ST_GAME_OVER;
                        win_nxt = WIN_P2;
                    end else begin
                        nxt      = ST_POINT;
                        load     = 1'b1;
                        load_val = POINT_LD;
                    end
                end else if (miss_right) begin
                    p1_nxt  = p1_inc;
                    dir_nxt = DIR_RIGHT;
                    if (p1_inc == WIN_VAL) begin
                        nxt     = ST_GAME_OVER;
                        win_nxt = WIN_P1;
                    end else begin
                        nxt      = ST_POINT;
                        load     = 1'b1;
                        load_val = POINT_LD;
                    end
                end else if (pause_edge) begin
                    nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_edge) nxt = ST_PLAY;
            end
            ST_POINT: begin
                if (done) begin
                    nxt     = ST_SERVE;
                    rst_nxt = 1'b1;
                    load    = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change with
// its cycle; the monitor pops and compares whenever the outputs move.
module tb_pong_match_ctrl;

    localparam int SF = 60;
    localparam int PF = 90;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_GO    = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       rst;
        logic       pad;
        logic       dir;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [1:0] win;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic btn_start = 1'b0;
    logic btn_pause = 1'b0;
    logic miss_left = 1'b0;
    logic miss_right = 1'b0;
    logic [2:0] state;
    logic ball_run, ball_reset, paddle_en, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;

    pong_match_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .state     (state),
        .ball_run  (ball_run),
        .ball_reset(ball_reset),
        .paddle_en (paddle_en),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   q_cyc[$];
    vec_t q_v[$];
    string q_nm[$];
    vec_t m;
    bit   stim_done = 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int dc, input string nm);
        q_cyc.push_back(cyc + dc);
        q_v.push_back(m);
        q_nm.push_back(nm);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        m.st = S_SERVE; m.rst = 1'b1;
        m.p1 = 4'd0; m.p2 = 4'd0; m.win = 2'b00;
        expect_at(2, "start_serve");
        m.rst = 1'b0; m.pad = 1'b1;
        expect_at(3, "start_paddle");
        step(4);
        btn_start = 1'b0;
        step(2);
    endtask

    task automatic serve();
        ticks(SF - 1);
        frame_tick = 1'b1;
        m.st = S_PLAY;
        expect_at(1, "serve_to_play");
        m.run = 1'b1;
        expect_at(2, "play_ball_run");
        step(1);
        frame_tick = 1'b0;
        step(2);
    endtask

    task automatic point();
        ticks(PF - 1);
        frame_tick = 1'b1;
        m.st = S_SERVE; m.rst = 1'b1;
        expect_at(1, "point_to_serve");
        m.rst = 1'b0; m.pad = 1'b1;
        expect_at(2, "point_serve_en");
        step(1);
        frame_tick = 1'b0;
        step(2);
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left = l;
        miss_right = r;
        if (l && r) begin
            m.st = S_SERVE; m.rst = 1'b1;
            expect_at(1, "replay");
            m.rst = 1'b0; m.run = 1'b0;
            expect_at(2, "replay_en");
        end else begin
            if (l) begin
                m.p2 = m.p2 + 4'd1; m.dir = 1'b1;
                m.st = (m.p2 == 4'd5) ? S_GO : S_POINT;
                if (m.p2 == 4'd5) m.win = 2'b10;
            end else begin
                m.p1 = m.p1 + 4'd1; m.dir = 1'b0;
                m.st = (m.p1 == 4'd5) ? S_GO : S_POINT;
                if (m.p1 == 4'd5) m.win = 2'b01;
            end
            expect_at(1, l ? "miss_left" : "miss_right");
            m.run = 1'b0; m.pad = 1'b0;
            expect_at(2, "miss_motion_off");
        end
        step(1);
        miss_left = 1'b0;
        miss_right = 1'b0;
        step(2);
    endtask

    task automatic raw_event(input logic l, input logic r, input logic t);
        miss_left = l;
        miss_right = r;
        frame_tick = t;
        step(1);
        miss_left = 1'b0;
        miss_right = 1'b0;
        frame_tick = 1'b0;
        step(1);
    endtask

    initial begin
        m = '0;
        m.st = S_IDLE;
        expect_at(1, "reset_state");
        step(3);
        reset = 1'b0;
        step(2);

        press_start();
        serve();
        miss(1'b0, 1'b1);
        point();
        serve();

        for (int i = 0; i < 5; i++) begin
            miss(1'b1, 1'b0);
            if (i < 4) begin
                point();
                serve();
            end
        end

        raw_event(1'b1, 1'b0, 1'b1);
        raw_event(1'b0, 1'b1, 1'b0);
        raw_event(1'b1, 1'b1, 1'b1);
        btn_pause = 1'b1;
        step(4);
        btn_pause = 1'b0;
        step(2);

        press_start();
        serve();
        miss(1'b1, 1'b1);
        serve();

        btn_start = 1'b1;
        step(4);
        btn_start = 1'b0;
        step(2);

        btn_pause = 1'b1;
        m.st = S_PAUSE;
        expect_at(2, "pause_enter");
        m.run = 1'b0; m.pad = 1'b0;
        expect_at(3, "pause_motion_off");
        step(4);
        for (int i = 0; i < 10; i++) raw_event(i[0], ~i[0], 1'b1);
        step(76);
        btn_pause = 1'b0;
        step(2);
        btn_pause = 1'b1;
        m.st = S_PLAY;
        expect_at(2, "pause_exit");
        m.run = 1'b1; m.pad = 1'b1;
        expect_at(3, "resume_motion");
        step(4);
        btn_pause = 1'b0;
        step(2);

        btn_pause = 1'b1;
        step(1);
        miss(1'b0, 1'b1);
        btn_pause = 1'b0;
        step(2);
        point();
        serve();
        miss(1'b0, 1'b1);
        point();
        serve();
        miss(1'b0, 1'b1);
        step(5);

        reset = 1'b1;
        m = '0;
        m.st = S_IDLE;
        expect_at(1, "reset_mid_point");
        step(1);
        reset = 1'b0;
        ticks(10);
        step(5);
        stim_done = 1'b1;
    end

    int total = 0;
    int bad = 0;
    bit started = 1'b0;
    vec_t cur, prev, ev;
    int ec;
    string en;

    always @(negedge clk) begin
        cur = {state, ball_run, ball_reset, paddle_en, serve_dir,
               score_p1, score_p2, winner};
        if (!started || cur != prev) begin
            total++;
            if (q_v.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %h at cyc %0d, want no change",
                         cur, cyc);
            end else begin
                ec = q_cyc.pop_front();
                ev = q_v.pop_front();
                en = q_nm.pop_front();
                if (cur != ev || cyc != ec) begin
                    bad++;
                    $display("FAIL %s: got %h at cyc %0d, want %h at cyc %0d",
                             en, cur, cyc, ev, ec);
                end
            end
            prev = cur;
            started = 1'b1;
        end
        if (stim_done || cyc > 20000) begin
            if (!stim_done) begin
                total++;
                bad++;
                $display("FAIL timeout: got cyc %0d, want stimulus done", cyc);
            end
            while (q_v.size() > 0) begin
                total++;
                bad++;
                ec = q_cyc.pop_front();
                ev = q_v.pop_front();
                en = q_nm.pop_front();
                $display("FAIL %s: got no change, want %h at cyc %0d",
                         en, ev, ec);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule
